// File: rtl/clock_timer_bank.sv
// Shared tick prescaler, tick-rate square wave and N_CH independent down-counting
// timers (one-shot or periodic) for pulse-sequence timing.
//
// state  | meaning
// IDLE   | stopped, nothing pending
// RUN    | counting down on each tick
// DONE   | one-shot expired (or zero count); timeup held until start/stop
module clock_timer_bank #(
    parameter int N_CH     = 4,
    parameter int TW       = 16,
    parameter int TICK_DIV = 4000
) (
    input  logic                 GLA,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      start,
    input  logic [N_CH-1:0]      stop,
    input  logic [N_CH-1:0]      mode,
    input  logic [N_CH*TW-1:0]   timer_para,
    output logic                 tick,
    output logic                 clock_10khz,
    output logic [N_CH-1:0]      busy,
    output logic [N_CH-1:0]      timeup,
    output logic [N_CH-1:0]      expire
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic          tick_en;

    // Channels act on tick_en so expire lands in the same cycle as the tick output.
    assign tick_en  = (pcnt == PMAX);
    assign pcnt_nxt = tick_en ? '0 : pcnt + PW'(1);

    // clock_10khz follows pcnt_nxt so its rising edge leads tick by TICK_DIV/2.
    always_ff @(posedge GLA or negedge rst_n) begin
        if (!rst_n) begin
            pcnt        <= '0;
            tick        <= 1'b0;
            clock_10khz <= 1'b0;
        end else begin
            pcnt        <= pcnt_nxt;
            tick        <= tick_en;
            clock_10khz <= (pcnt_nxt >= HALF);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [1:0]    state;
        logic [TW-1:0] period;
        logic [TW-1:0] cnt;
        logic          per_mode;
        logic          expire_r;
        logic [TW-1:0] para;

        assign para = timer_para[k*TW +: TW];

        always_ff @(posedge GLA or negedge rst_n) begin
            if (!rst_n) begin
                state    <= S_IDLE;
                period   <= '0;
                cnt      <= '0;
                per_mode <= 1'b0;
                expire_r <= 1'b0;
            end else begin
                expire_r <= 1'b0;
                if (stop[k]) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end else if (start[k]) begin
                    period   <= para;
                    per_mode <= mode[k];
                    cnt      <= para;
                    if (para == '0) begin
                        state    <= S_DONE;
                        expire_r <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end else if (state == S_RUN && tick_en) begin
                    if (cnt == TW'(1)) begin
                        expire_r <= 1'b1;
                        if (per_mode) begin
                            cnt <= period;
                        end else begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
            end
        end

        // Encoding puts busy and timeup directly on state flops.
        assign busy[k]   = state[0];
        assign timeup[k] = state[1];
        assign expire[k] = expire_r;
    end

endmodule

// File: tb/tb_clock_timer_bank.sv
// Bench for clock_timer_bank: directed scenarios plus random start/stop traffic,
// compared every cycle against an event-level timer model.
module tb_clock_timer_bank;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam int TD = 4;

    logic              GLA = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      start = '0;
    logic [N-1:0]      stop = '0;
    logic [N-1:0]      mode = '0;
    logic [N*TW-1:0]   timer_para = '0;
    logic              tick;
    logic              clock_10khz;
    logic [N-1:0]      busy;
    logic [N-1:0]      timeup;
    logic [N-1:0]      expire;

    int checks = 0;
    int failures = 0;

    // model: k = rising edges since reset release; tick events on edges with k % TD == 0
    int k;
    int m_st[N];     // 0 idle, 1 run, 2 done
    int m_rem[N];
    int m_per[N];
    int m_mode[N];
    bit m_exp[N];

    clock_timer_bank #(.N_CH(N), .TW(TW), .TICK_DIV(TD)) dut (
        .GLA(GLA), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .timer_para(timer_para), .tick(tick), .clock_10khz(clock_10khz),
        .busy(busy), .timeup(timeup), .expire(expire)
    );

    always #5 GLA = ~GLA;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int c = 0; c < N; c++) begin
            m_st[c] = 0; m_rem[c] = 0; m_per[c] = 0; m_mode[c] = 0; m_exp[c] = 0;
        end
    endtask

    task automatic model_edge();
        int p;
        bit tev;
        k++;
        tev = (k % TD == 0);
        for (int c = 0; c < N; c++) begin
            p = int'(timer_para[c*TW +: TW]);
            m_exp[c] = 0;
            if (stop[c]) begin
                m_st[c] = 0; m_rem[c] = 0;
            end else if (start[c]) begin
                m_per[c] = p; m_mode[c] = int'(mode[c]); m_rem[c] = p;
                if (p == 0) begin m_st[c] = 2; m_exp[c] = 1; end
                else m_st[c] = 1;
            end else if (m_st[c] == 1 && tev) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_exp[c] = 1;
                    if (m_mode[c] == 1) m_rem[c] = m_per[c];
                    else m_st[c] = 2;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("tick", 32'(tick), 32'(k > 0 && k % TD == 0));
        check("clock_10khz", 32'(clock_10khz), 32'((k % TD) >= TD / 2));
        for (int c = 0; c < N; c++) begin
            check($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_st[c] == 1));
            check($sformatf("timeup%0d", c), 32'(timeup[c]), 32'(m_st[c] == 2));
            check($sformatf("expire%0d", c), 32'(expire[c]), 32'(m_exp[c]));
        end
    endtask

    task automatic step();
        @(posedge GLA);
        model_edge();
        @(negedge GLA);
        compare_all();
        start = '0;
        stop  = '0;
    endtask

    task automatic arm(input int c, input int para, input bit md);
        timer_para[c*TW +: TW] = TW'(para);
        mode[c]  = md;
        start[c] = 1'b1;
    endtask

    task automatic run_until_timeup(input int c, input int bound);
        bit found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (timeup[c]) found = 1;
        end
        check($sformatf("timeup_reached%0d", c), 32'(found), 32'd1);
    endtask

    initial begin
        int n, last, cnt, r;

        // reset and prescaler
        model_reset();
        repeat (3) @(negedge GLA);
        compare_all();
        rst_n = 1'b1;
        repeat (12) step();

        // one-shot ch0, 3 ticks
        arm(0, 3, 0);
        step();
        cnt = 0;
        for (int i = 0; i < 40 && !timeup[0]; i++) begin
            step();
            cnt += int'(expire[0]);
        end
        check("oneshot_expires", 32'(cnt), 32'd1);
        repeat (6) step();

        // periodic ch1, 2 ticks: expire every 2*TD cycles
        arm(1, 2, 1);
        step();
        n = 0; last = -1;
        for (int i = 0; i < 100 && n < 5; i++) begin
            step();
            if (expire[1]) begin
                if (last >= 0) check("periodic_gap", 32'(k - last), 32'(2 * TD));
                last = k;
                n++;
            end
        end
        check("periodic_count", 32'(n), 32'd5);
        stop[1] = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(expire[1]);
        end
        check("stop_no_expire", 32'(cnt), 32'd0);

        // zero count, then restart mid-count at remaining 2
        arm(2, 0, 1);
        step();
        repeat (10) step();
        arm(3, 4, 0);
        step();
        for (int i = 0; i < 40 && m_rem[3] != 2; i++) step();
        check("restart_point", 32'(m_rem[3]), 32'd2);
        arm(3, 5, 0);
        step();
        run_until_timeup(3, 60);

        // start+stop together
        arm(0, 3, 0);
        stop[0] = 1'b1;
        step();
        repeat (4) step();

        // start coincident with the expiring tick
        arm(1, 1, 0);
        step();
        for (int i = 0; i < 2 * TD && ((k + 1) % TD != 0); i++) step();
        check("coincide_phase", 32'((k + 1) % TD), 32'd0);
        arm(1, 3, 0);
        step();
        run_until_timeup(1, 40);

        // asynchronous reset mid-run
        arm(0, 5, 1);
        arm(2, 6, 0);
        step();
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge GLA);
        compare_all();
        rst_n = 1'b1;
        repeat (3) step();

        // independence: 1..4 ticks, mixed modes
        for (int c = 0; c < N; c++) arm(c, c + 1, c[0]);
        step();
        repeat (40) step();
        stop = '1;
        step();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++) begin
                r = int'($urandom_range(0, 99));
                if (r < 2) begin
                    arm(c, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
                    stop[c] = 1'b1;
                end else if (r < 5) begin
                    stop[c] = 1'b1;
                end else if (r < 12) begin
                    arm(c, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
